// File: rtl/ps2_key_tx_if.sv
// Key-event handshake bundle between the controller core and the PS/2 transmitter.
// The core drives the event fields; the transmitter reports ready/busy/done.
interface ps2_key_tx_if;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       busy;
    logic       done;

    modport master (
        output key_valid, key_code, key_ext, key_release,
        input  key_ready, busy, done
    );

    modport slave (
        input  key_valid, key_code, key_ext, key_release,
        output key_ready, busy, done
    );
endinterface

// File: rtl/ps2_key_tx.sv
// PS/2 device-to-host transmitter: expands one key event into its Set-2 byte
// sequence and clocks each byte out as an 11-bit frame, yielding to host inhibit.
module ps2_key_tx #(
    parameter int HALF_DIV = 400,
    parameter int GAP_DIV  = 800
) (
    input  logic           clk,
    input  logic           rst,
    ps2_key_tx_if.slave    key_if,
    input  logic           ps2_clk_in,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe
);
    localparam int CNT_MAX = (GAP_DIV > HALF_DIV) ? GAP_DIV : HALF_DIV;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_DIV - 1);
    localparam logic [CW-1:0] INH_FIRST = CW'(3);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT_IDLE, ST_BIT_HI, ST_BIT_LO, ST_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      last_q, last_d;
    logic [2:0][7:0] seq_q, seq_d;
    logic [2:0][7:0] seq_ld_s;
    logic [1:0]      last_ld_s;
    logic            sync1_q, clk_s_q;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            done_q, done_d;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic v;
        case (idx)
            4'd0:                                    v = 1'b0;
            4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8:                  v = b[3'(idx - 4'd1)];
            4'd9:                                    v = odd_parity(b);
            default:                                 v = 1'b1;
        endcase
        return v;
    endfunction

    // Byte sequence for the offered event: [E0] [F0] code, element 0 sent first.
    always_comb begin
        seq_ld_s  = {24{1'b0}};
        last_ld_s = 2'd0;
        case ({key_if.key_ext, key_if.key_release})
            2'b11: begin
                seq_ld_s  = {key_if.key_code, 8'hF0, 8'hE0};
                last_ld_s = 2'd2;
            end
            2'b10: begin
                seq_ld_s  = {8'h00, key_if.key_code, 8'hE0};
                last_ld_s = 2'd1;
            end
            2'b01: begin
                seq_ld_s  = {8'h00, key_if.key_code, 8'hF0};
                last_ld_s = 2'd1;
            end
            default: begin
                seq_ld_s  = {16'h0000, key_if.key_code};
                last_ld_s = 2'd0;
            end
        endcase
    end

    // Next-state logic; line drives are derived from the next state so they register with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        last_d  = last_q;
        seq_d   = seq_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_if.key_valid) begin
                    state_d = ST_WAIT_IDLE;
                    cnt_d   = {CW{1'b0}};
                    sel_d   = 2'd0;
                    seq_d   = seq_ld_s;
                    last_d  = last_ld_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (!clk_s_q) begin
                    cnt_d = {CW{1'b0}};
                end else if (cnt_q == HALF_LAST) begin
                    state_d = ST_BIT_HI;
                    cnt_d   = {CW{1'b0}};
                    idx_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BIT_HI: begin
                // Early cycles of the half still see our own low phase through the synchroniser.
                if ((idx_q != 4'd10) && (cnt_q >= INH_FIRST) && !clk_s_q) begin
                    state_d = ST_WAIT_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (cnt_q == HALF_LAST) begin
                    state_d = ST_BIT_LO;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BIT_LO: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = {CW{1'b0}};
                    if (idx_q == 4'd10) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_BIT_HI;
                        idx_d   = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = {CW{1'b0}};
                    if (sel_q == last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                        sel_d   = sel_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        clk_oe_d = (state_d == ST_BIT_LO);
        if ((state_d == ST_BIT_HI) || (state_d == ST_BIT_LO)) begin
            data_oe_d = ~frame_bit(seq_q[sel_d], idx_d);
        end else begin
            data_oe_d = 1'b0;
        end
    end

    // State, synchroniser and registered line drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CW{1'b0}};
            idx_q     <= 4'd0;
            sel_q     <= 2'd0;
            last_q    <= 2'd0;
            seq_q     <= {24{1'b0}};
            sync1_q   <= 1'b1;
            clk_s_q   <= 1'b1;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            seq_q     <= seq_d;
            sync1_q   <= ps2_clk_in;
            clk_s_q   <= sync1_q;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
        end
    end

    assign key_if.key_ready = (state_q == ST_IDLE);
    assign key_if.busy      = (state_q != ST_IDLE);
    assign key_if.done      = done_q;
    assign ps2_clk_oe       = clk_oe_q;
    assign ps2_data_oe      = data_oe_q;
endmodule

// File: tb/tb_ps2_key_tx.sv
// Self-checking bench for ps2_key_tx: a line monitor decodes frames off the
// open-drain drives and scores them against frames queued at stimulus time.
module tb_ps2_key_tx;
    localparam int HALF_DIV = 4;
    localparam int GAP_DIV  = 8;

    logic clk = 1'b0;
    logic rst;
    logic host_hold;
    logic ps2_clk_in;
    logic ps2_clk_oe;
    logic ps2_data_oe;

    ps2_key_tx_if kif ();

    assign ps2_clk_in = ~(ps2_clk_oe | host_hold);

    ps2_key_tx #(.HALF_DIV(HALF_DIV), .GAP_DIV(GAP_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_if      (kif.slave),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    logic [10:0] exp_q[$];
    logic [10:0] rx_log[$];
    int frames_rx = 0;
    int aborts    = 0;
    int done_cnt  = 0;

    task automatic push_event(input logic [7:0] code, input logic ext, input logic rel);
        if (ext) exp_q.push_back(mk_frame(8'hE0));
        if (rel) exp_q.push_back(mk_frame(8'hF0));
        exp_q.push_back(mk_frame(code));
    endtask

    // Host-side frame decoder: a bit is taken when the device pulls the clock low.
    int          bitcnt = 0;
    int          zrun   = 0;
    int          orun   = 0;
    logic        prev_oe = 1'b0;
    logic [10:0] fr;
    always @(negedge clk) begin
        if (rst) begin
            bitcnt  = 0;
            zrun    = 0;
            orun    = 0;
            prev_oe = 1'b0;
        end else begin
            if (ps2_clk_oe && !prev_oe) begin
                if (bitcnt > 0) check("bit_hi_len", zrun, HALF_DIV);
                fr[bitcnt] = ~ps2_data_oe;
                bitcnt++;
                zrun = 0;
                if (bitcnt == 11) begin
                    frames_rx++;
                    rx_log.push_back(fr);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %h, none expected", fr);
                    end else begin
                        check("frame", fr, exp_q.pop_front());
                    end
                    bitcnt = 0;
                end
            end else if (!ps2_clk_oe && prev_oe) begin
                check("bit_lo_len", orun, HALF_DIV);
                orun = 0;
            end
            if (ps2_clk_oe) begin
                orun++;
            end else begin
                zrun++;
                if (zrun > HALF_DIV + 1 && bitcnt != 0) begin
                    aborts++;
                    bitcnt = 0;
                end
            end
            prev_oe = ps2_clk_oe;
            if (kif.done) done_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!kif.key_ready && n < 5000) begin
            tick();
            n++;
        end
        check("ready_wait", kif.key_ready, 1'b1);
    endtask

    task automatic do_event(input logic [7:0] code, input logic ext, input logic rel);
        wait_ready();
        kif.key_code    = code;
        kif.key_ext     = ext;
        kif.key_release = rel;
        kif.key_valid   = 1'b1;
        push_event(code, ext, rel);
        tick();
        kif.key_valid = 1'b0;
        check("busy_after_accept", kif.busy, 1'b1);
        check("ready_after_accept", kif.key_ready, 1'b0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!kif.done && n < 5000) begin
            tick();
            n++;
        end
        check("done_seen", kif.done, 1'b1);
        check("ready_in_done", kif.key_ready, 1'b1);
        tick();
        check("done_one_cycle", kif.done, 1'b0);
    endtask

    typedef struct {
        logic [7:0]  code;
        logic        ext;
        logic        rel;
        int          nfr;
        logic [10:0] first;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d0;
        int f0;
        int n;
        logic bad;

        vecs[0] = '{8'h1C, 1'b0, 1'b0, 1, 11'h438};
        vecs[1] = '{8'h74, 1'b1, 1'b1, 3, 11'h5C0};
        vecs[2] = '{8'h5A, 1'b0, 1'b1, 2, 11'h7E0};
        vecs[3] = '{8'h75, 1'b1, 1'b0, 2, 11'h5C0};
        vecs[4] = '{8'h00, 1'b0, 1'b0, 1, 11'h600};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 2, 11'h7E0};

        rst             = 1'b1;
        host_hold       = 1'b0;
        kif.key_valid   = 1'b0;
        kif.key_code    = 8'h00;
        kif.key_ext     = 1'b0;
        kif.key_release = 1'b0;
        repeat (3) tick();
        check("rst_ready", kif.key_ready, 1'b1);
        check("rst_busy", kif.busy, 1'b0);
        check("rst_done", kif.done, 1'b0);
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_data_oe", ps2_data_oe, 1'b0);
        rst = 1'b0;
        repeat (3) tick();

        // Table-driven events on an idle line.
        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            f0 = rx_log.size();
            do_event(vecs[i].code, vecs[i].ext, vecs[i].rel);
            n = 1;
            while (!ps2_data_oe && n < 100) begin
                tick();
                n++;
            end
            check("start_latency", (n >= HALF_DIV + 1) && (n <= HALF_DIV + 3), 1'b1);
            wait_done();
            check("done_count", done_cnt - d0, 1);
            check("frame_count", rx_log.size() - f0, vecs[i].nfr);
            if (rx_log.size() > f0) check("first_frame", rx_log[f0], vecs[i].first);
            check("scoreboard_empty", exp_q.size(), 0);
            tick();
        end

        // Host inhibit held across accept.
        host_hold = 1'b1;
        d0 = done_cnt;
        do_event(8'h1C, 1'b0, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ps2_clk_oe || ps2_data_oe) bad = 1'b1;
            tick();
        end
        check("inhibit_no_oe", bad, 1'b0);
        host_hold = 1'b0;
        n = 0;
        while (!ps2_data_oe && n < 100) begin
            tick();
            n++;
        end
        check("inhibit_release_latency", (n >= HALF_DIV + 2) && (n <= HALF_DIV + 4), 1'b1);
        wait_done();
        check("inhibit_done", done_cnt - d0, 1);
        check("inhibit_scoreboard", exp_q.size(), 0);

        // Host inhibit during BIT_HI of idx5 of the F0 byte.
        d0 = done_cnt;
        f0 = frames_rx;
        n  = aborts;
        do_event(8'h74, 1'b1, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if (frames_rx - f0 == 1 && bitcnt == 5 && !ps2_clk_oe) break;
            tick();
        end
        check("abort_reached_idx5", (frames_rx - f0 == 1) && (bitcnt == 5), 1'b1);
        host_hold = 1'b1;
        repeat (6) tick();
        check("abort_clk_released", ps2_clk_oe, 1'b0);
        check("abort_data_released", ps2_data_oe, 1'b0);
        check("abort_still_busy", kif.busy, 1'b1);
        repeat (14) tick();
        host_hold = 1'b0;
        wait_done();
        check("abort_count", aborts - n, 1);
        check("abort_frames", frames_rx - f0, 3);
        check("abort_done", done_cnt - d0, 1);
        check("abort_scoreboard", exp_q.size(), 0);

        // Reset during BIT_LO of the second byte.
        f0 = frames_rx;
        do_event(8'h74, 1'b1, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if (frames_rx - f0 == 1 && ps2_clk_oe && bitcnt >= 2) break;
            tick();
        end
        check("rst_reached_byte2", ps2_clk_oe, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_mid_data_oe", ps2_data_oe, 1'b0);
        exp_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_mid_ready", kif.key_ready, 1'b1);
        check("rst_mid_busy", kif.busy, 1'b0);
        f0 = frames_rx;
        bad = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (ps2_clk_oe || ps2_data_oe) bad = 1'b1;
            tick();
        end
        check("rst_no_activity", bad, 1'b0);
        check("rst_no_frames", frames_rx - f0, 0);

        // key_valid held high with a changing code while busy.
        d0 = done_cnt;
        kif.key_code    = 8'h1C;
        kif.key_ext     = 1'b0;
        kif.key_release = 1'b0;
        kif.key_valid   = 1'b1;
        push_event(8'h1C, 1'b0, 1'b0);
        tick();
        bad = 1'b0;
        n = 0;
        while (!kif.done && n < 3000) begin
            if (kif.key_ready) bad = 1'b1;
            kif.key_code = 8'($urandom);
            tick();
            n++;
        end
        check("hold_ready_low_while_busy", bad, 1'b0);
        check("hold_done_seen", kif.done, 1'b1);
        check("hold_ready_in_done", kif.key_ready, 1'b1);
        kif.key_code = 8'h2B;
        push_event(8'h2B, 1'b0, 1'b0);
        tick();
        kif.key_valid = 1'b0;
        check("hold_accept_after_done", kif.busy, 1'b1);
        wait_done();
        check("hold_done_count", done_cnt - d0, 2);
        check("hold_scoreboard", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
